param_alu: RTL and testbench
============================

Name: param_alu

Overview:
- Parametrised successor of the team's 8-bit tiny ALU.
- WIDTH-bit operands with a 2*WIDTH-bit result.
- Adds a subtract op, operand latching, a busy/accept handshake and a configurable multiply latency.
- Sits between the testbench-driven command interface and the result scoreboard, one operation at a time.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- MUL_LATENCY, 3, cycles from multiply accept to done; legal range 1..16.

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled on a rising edge.
- op  input  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101 sub, 110/111 illegal.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- result  output  2*WIDTH  registered result.
- done  output  1  one-cycle completion pulse.
- busy  output  1  high while an accepted op is executing.
- err  output  1  illegal-op pulse; present only with PARAM_ALU_ERR_EN.

Behaviour:
- Reset is synchronous and active-low. When reset_n=0 at an edge: result=0, done=0, busy=0, err=0, state=IDLE, latency counter=0.
- Reset mid-operation aborts the op: no done, and result is cleared to 0.
- Accept: at edge E, start=1, busy=0 and op is in {add, and, xor, mul, sub}.
  - A, B and op are latched into internal registers.
  - busy goes to 1 after E.
- Ignored requests:
  - start while busy=1 is ignored, not queued.
  - op=no_op or an illegal op is never accepted, and no done is produced.
- Inputs A, B, op may change freely while busy=1 without affecting the result.
- States:
  - IDLE → EXEC on accept.
  - EXEC → DONE when the counter expires.
  - DONE → IDLE unconditionally after one cycle.
- Latency counter is loaded with the op latency minus 1 on accept and decrements in EXEC.
- Single-cycle ops (add, and, xor, sub): result and done=1 registered at E+1.
- mul: result and done=1 registered at E+MUL_LATENCY.
- MUL_LATENCY=1 behaves exactly like a single-cycle op.
- done is high for exactly one cycle (the DONE state). busy is low during DONE.
- Back-to-back: a start accepted at the done edge is legal, giving peak throughput of one op per 2 cycles for single-cycle ops.
- Arithmetic (all results 2*WIDTH bits):
  - add: zero-extended A+B; carry lands in bit WIDTH.
  - and, xor: bitwise, zero-extended.
  - sub: two's-complement A-B, sign-extended to 2*WIDTH (modulo 2^(2*WIDTH)).
  - mul: full unsigned product.
- result holds its last value until the next done edge.
- done and busy are never high in the same cycle.

Optional Feature:
- Macro: PARAM_ALU_ERR_EN.
- Defined:
  - err port exists.
  - start=1 with busy=0 and op in {110, 111} at edge E gives err=1 for the single cycle after E.
  - busy and done are unaffected, and result is unchanged.
  - start with op=no_op never raises err.
  - err resets to 0.
- Undefined:
  - err port is absent.
  - Illegal ops are silently ignored, the same as no_op.

Test Plan:
- WIDTH=8: reset_n=0 for 2 cycles with start=1, op=add → result=0x0000, done=0, busy=0 throughout.
- add A=0xFF, B=0x01 accepted at E → busy=1 for one cycle; done=1 and result=0x0100 at E+1; done=0 at E+2.
- MUL_LATENCY=3: mul A=0xFF, B=0xFF at E; at E+1 change A=0x00 and pulse start → done only at E+3 with result=0xFE01; the second start produces no effect.
- sub A=0x00, B=0x01 → result=0xFFFF. Immediately after, xor A=0xF0, B=0xFF, accepted in the done cycle → result=0x000F one edge later.
- mul accepted at E, reset_n=0 at E+2 → no done pulse, result=0, busy=0 at E+3; an add accepted after reset completes normally.
- With PARAM_ALU_ERR_EN: start with op=111, A=0x12, B=0x34 → err=1 for one cycle, done=0, busy=0, result unchanged. Without the macro: no response. In both builds op=000 produces nothing.

Source files
------------

// File: rtl/param_alu.sv
`default_nettype none
// ============================================================================
//  Module   : param_alu
//  Purpose  : Parametrised WIDTH-bit ALU with a 2*WIDTH-bit registered
//             result. Supports add, and, xor, sub (all single cycle) and an
//             unsigned multiply with a configurable latency. Operands and
//             opcode are latched on accept, so the inputs may change freely
//             while the operation executes.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH        operand width in bits (2..32)
//    MUL_LATENCY  cycles from multiply accept to done (1..16)
//  Ports
//    clk       in   rising-edge clock
//    reset_n   in   synchronous active-low reset
//    start     in   operation request, sampled on the rising edge
//    op        in   3-bit opcode (000 nop, 001 add, 010 and, 011 xor,
//                   100 mul, 101 sub, 110/111 illegal)
//    A, B      in   WIDTH-bit unsigned operands
//    result    out  2*WIDTH-bit registered result
//    done      out  one-cycle completion pulse
//    busy      out  high while an accepted operation executes
//    err       out  one-cycle illegal-opcode pulse (PARAM_ALU_ERR_EN only)
//  Build option
//    PARAM_ALU_ERR_EN  when defined, adds the err port; otherwise illegal
//                      opcodes are ignored exactly like no_op.
// ============================================================================
module param_alu #(
  parameter int WIDTH       = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy
`ifdef PARAM_ALU_ERR_EN
  ,
  output logic                 err
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_OP_NOP = 3'b000;
  localparam logic [2:0] c_OP_ADD = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_XOR = 3'b011;
  localparam logic [2:0] c_OP_MUL = 3'b100;
  localparam logic [2:0] c_OP_SUB = 3'b101;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_EXEC = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  // Counter holds (latency - 1); MUL_LATENCY=1 degenerates to a 1-bit counter
  // that is always loaded with zero.
  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] c_MUL_CNT = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  localparam int RW = 2 * WIDTH;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [2:0]       op_q,     op_d;
  logic [RW-1:0]    result_q, result_d;

  logic             w_legal_op;
  logic             w_accept;
  logic             w_not_exec;
  logic [RW-1:0]    w_a_ext;
  logic [RW-1:0]    w_b_ext;
  logic [RW-1:0]    w_alu;

  // Only the five real operations may be accepted; no_op and 110/111 never
  // enter EXEC and therefore never produce done.
  always_comb begin
    w_legal_op = 1'b0;
    case (op)
      c_OP_ADD, c_OP_AND, c_OP_XOR, c_OP_MUL, c_OP_SUB: w_legal_op = 1'b1;
      default:                                          w_legal_op = 1'b0;
    endcase
  end

  // IDLE and DONE both have busy low, so a request arriving in the DONE
  // cycle is accepted and back-to-back single-cycle ops run every 2 cycles.
  assign w_not_exec = (state_q != c_ST_EXEC);
  assign w_accept   = start & w_not_exec & w_legal_op;

  // --------------------------------------------------------------------------
  // Arithmetic on the latched operands. Zero-extending both operands to
  // 2*WIDTH before subtracting gives the sign-extended difference modulo
  // 2^(2*WIDTH), and the truncated 2*WIDTH product is the full W x W product.
  // --------------------------------------------------------------------------
  assign w_a_ext = {{WIDTH{1'b0}}, a_q};
  assign w_b_ext = {{WIDTH{1'b0}}, b_q};

  always_comb begin
    w_alu = '0;
    case (op_q)
      c_OP_ADD: w_alu = w_a_ext + w_b_ext;
      c_OP_AND: w_alu = w_a_ext & w_b_ext;
      c_OP_XOR: w_alu = w_a_ext ^ w_b_ext;
      c_OP_SUB: w_alu = w_a_ext - w_b_ext;
      c_OP_MUL: w_alu = w_a_ext * w_b_ext;
      c_OP_NOP: w_alu = '0;
      default:  w_alu = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Process 1: state register (also holds the datapath registers)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= c_ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= c_OP_NOP;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  // --------------------------------------------------------------------------
  // Process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;

    case (state_q)
      c_ST_IDLE, c_ST_DONE: begin
        if (w_accept) begin
          state_d = c_ST_EXEC;
          a_d     = A;
          b_d     = B;
          op_d    = op;
          cnt_d   = (op == c_OP_MUL) ? c_MUL_CNT : '0;
        end else begin
          state_d = c_ST_IDLE;
        end
      end

      c_ST_EXEC: begin
        // The result is captured on the same edge that enters DONE, so
        // result and done become visible together.
        if (cnt_q == '0) begin
          state_d  = c_ST_DONE;
          result_d = w_alu;
        end else begin
          cnt_d = cnt_q - c_CNT_ONE;
        end
      end

      default: begin
        state_d = c_ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Process 3: outputs decoded from the registered state
  // --------------------------------------------------------------------------
  always_comb begin
    done = (state_q == c_ST_DONE);
    busy = (state_q == c_ST_EXEC);
  end

  assign result = result_q;

`ifdef PARAM_ALU_ERR_EN
  // --------------------------------------------------------------------------
  // Illegal-opcode flag: a request with op 110/111 while not busy pulses err
  // for one cycle and leaves the FSM and result untouched.
  // --------------------------------------------------------------------------
  logic err_q, err_d;

  assign err_d = start & w_not_exec & (op[2:1] == 2'b11);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_alu
//  Purpose  : Scoreboard bench for param_alu (WIDTH=8, MUL_LATENCY=3).
//             Stimulus pushes the expected result and completion cycle into a
//             queue; a negedge monitor pops and compares on every done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_alu;

  localparam int WIDTH       = 8;
  localparam int MUL_LATENCY = 3;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_ILL = 3'b111;

  logic                 clk;
  logic                 reset_n;
  logic                 start;
  logic [2:0]           op;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   result;
  logic                 done;
  logic                 busy;
`ifdef PARAM_ALU_ERR_EN
  logic                 err;
`endif

  param_alu #(
    .WIDTH       (WIDTH),
    .MUL_LATENCY (MUL_LATENCY)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .result  (result),
    .done    (done),
    .busy    (busy)
`ifdef PARAM_ALU_ERR_EN
    ,
    .err     (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drive a request at the current negedge; it is sampled at the next edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input int lat, input logic expect_done, input logic [15:0] r);
    exp_t e;
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    if (expect_done) begin
      e.res = r;
      e.due = cyc + 1 + lat;
      sb.push_back(e);
    end
  endtask

  // Monitor: pops on every done pulse and flags missing or unexpected ones.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("done_cycle", 32'(cyc), 32'(e.due));
        check("busy_low_in_done", 32'(busy), 32'd0);
      end
    end else if (sb.size() != 0 && sb[0].due < cyc) begin
      check("missing_done", 32'(done), 32'd1);
      void'(sb.pop_front());
    end
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b1;
    op      = OP_ADD;
    A       = 8'h11;
    B       = 8'h22;

    // Reset held for two edges with a pending add request.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_result", 32'(result), 32'h0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    reset_n = 1'b1;
    start   = 1'b0;
    step();

    // add with carry into bit WIDTH
    issue(OP_ADD, 8'hFF, 8'h01, 1, 1'b1, 16'h0100);
    step();
    start = 1'b0;
    check("add_busy", 32'(busy), 32'd1);
    check("add_done_early", 32'(done), 32'd0);
    step();
    step();
    check("add_done_pulse_end", 32'(done), 32'd0);
    check("add_idle_busy", 32'(busy), 32'd0);

    // mul with operand change and ignored start during execution
    issue(OP_MUL, 8'hFF, 8'hFF, MUL_LATENCY, 1'b1, 16'hFE01);
    step();
    A     = 8'h00;
    start = 1'b1;
    check("mul_busy1", 32'(busy), 32'd1);
    step();
    start = 1'b0;
    check("mul_busy2", 32'(busy), 32'd1);
    step();
    check("mul_busy3", 32'(busy), 32'd1);
    step();
    repeat (4) step();

    // sub borrow, then xor accepted in the done cycle
    issue(OP_SUB, 8'h00, 8'h01, 1, 1'b1, 16'hFFFF);
    step();
    start = 1'b0;
    step();
    check("sub_done_cycle", 32'(done), 32'd1);
    issue(OP_XOR, 8'hF0, 8'hFF, 1, 1'b1, 16'h000F);
    step();
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    step();
    step();

    // mul aborted by reset two edges after accept
    issue(OP_MUL, 8'h10, 8'h10, MUL_LATENCY, 1'b0, 16'h0);
    step();
    start = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    check("abort_result", 32'(result), 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    step();
    check("abort_result2", 32'(result), 32'h0);
    check("abort_busy2", 32'(busy), 32'd0);
    issue(OP_ADD, 8'h03, 8'h04, 1, 1'b1, 16'h0007);
    step();
    start = 1'b0;
    step();
    step();

    // illegal opcode
    issue(OP_ILL, 8'h12, 8'h34, 1, 1'b0, 16'h0);
    step();
    start = 1'b0;
    check("ill_busy", 32'(busy), 32'd0);
    check("ill_done", 32'(done), 32'd0);
    check("ill_result", 32'(result), 32'h0007);
`ifdef PARAM_ALU_ERR_EN
    check("ill_err", 32'(err), 32'd1);
    step();
    check("ill_err_end", 32'(err), 32'd0);
`else
    step();
`endif
    check("ill_busy2", 32'(busy), 32'd0);

    // no_op
    issue(OP_NOP, 8'h55, 8'hAA, 1, 1'b0, 16'h0);
    step();
    start = 1'b0;
    check("nop_busy", 32'(busy), 32'd0);
    check("nop_result", 32'(result), 32'h0007);
`ifdef PARAM_ALU_ERR_EN
    check("nop_err", 32'(err), 32'd0);
`endif
    step();

    // boundary patterns, back to back
    issue(OP_AND, 8'hFF, 8'h0F, 1, 1'b1, 16'h000F);
    step();
    start = 1'b0;
    step();
    issue(OP_ADD, 8'hFF, 8'hFF, 1, 1'b1, 16'h01FE);
    step();
    start = 1'b0;
    step();
    issue(OP_MUL, 8'h80, 8'h02, MUL_LATENCY, 1'b1, 16'h0100);
    step();
    start = 1'b0;
    repeat (6) step();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
